beat_rate_meter: RTL and testbench

Consumes the registered `over` flag from the threshold comparator and turns it into heart-rate data. It detects qualified beats (rising edges of `over`) and rejects re-triggers inside a refractory window. It measures the beat-to-beat interval in millisecond ticks and divides 60000 by that interval with an iterative divider to produce BPM. It also flags loss of signal when no beat arrives within a timeout; `bpm` and `bpm_valid` feed the display/UART stage.

---
 rtl/beat_rate_meter.sv | 141 ++++++++++++++
 tb/tb_beat_rate_meter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/beat_rate_meter.sv
// Turns the comparator's registered `over` flag into heart-rate data.
// It qualifies beats, measures the beat-to-beat interval in ms and computes BPM = 60000 / interval.
module beat_rate_meter #(
    parameter int TICK_DIV   = 100000,
    parameter int REFRACT_MS = 250,
    parameter int TIMEOUT_MS = 3000,
    parameter int CNT_W      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       over,
    output logic       beat,
    output logic [7:0] bpm,
    output logic       bpm_valid,
    output logic       no_signal
);

    localparam int               PS_W     = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] REFRACT  = CNT_W'(REFRACT_MS);
    localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(TIMEOUT_MS);
    localparam logic [15:0]      DIVIDEND = 16'd60000;
    localparam logic [4:0]       LAST_STEP = 5'd16;

    typedef enum logic [1:0] {IDLE, ARMED, DIVIDE} state_e;

    state_e           state_q;
    logic             overDly_q;
    logic [PS_W-1:0]  prescaler_q;
    logic [CNT_W-1:0] msCnt_q;
    logic [CNT_W-1:0] interval_q;
    logic [CNT_W-1:0] rem_q;
    logic [15:0]      quot_q;
    logic [4:0]       step_q;
    logic [7:0]       bpm_q;
    logic             beat_q;
    logic             bpmValid_q;
    logic             noSignal_q;

    logic             rise;
    logic             tick;
    logic             accept;
    logic [CNT_W:0]   trial;
    logic [CNT_W:0]   diff;
    logic             trialGe;
    logic [CNT_W-1:0] rem_d;
    logic [15:0]      quot_d;
    logic [7:0]       bpmSat;

    assign rise    = over & ~overDly_q;
    assign tick    = (prescaler_q == PS_LAST);
    assign accept  = rise && ((state_q == IDLE) ||
                              (state_q == ARMED && msCnt_q >= REFRACT));

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign trial   = {rem_q, quot_q[15]};
    assign diff    = trial - {1'b0, interval_q};
    assign trialGe = (trial >= {1'b0, interval_q});
    assign rem_d   = trialGe ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
    assign quot_d  = {quot_q[14:0], trialGe};
    assign bpmSat  = (quot_q > 16'd255) ? 8'hFF : quot_q[7:0];

    // Millisecond time base; both counters restart on every accepted beat so the
    // interval latched at the next beat is measured from the beat pulse itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q <= '0;
            msCnt_q     <= '0;
        end else if (accept) begin
            prescaler_q <= '0;
            msCnt_q     <= '0;
        end else if (state_q != IDLE) begin
            prescaler_q <= tick ? '0 : prescaler_q + 1'b1;
            if (tick && msCnt_q != CNT_MAX) begin
                msCnt_q <= msCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            overDly_q  <= 1'b0;
            interval_q <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            step_q     <= '0;
            bpm_q      <= '0;
            beat_q     <= 1'b0;
            bpmValid_q <= 1'b0;
            noSignal_q <= 1'b1;
        end else begin
            overDly_q  <= over;
            beat_q     <= 1'b0;
            bpmValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        beat_q  <= 1'b1;
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (accept) begin
                        beat_q     <= 1'b1;
                        interval_q <= msCnt_q;
                        rem_q      <= '0;
                        quot_q     <= DIVIDEND;
                        step_q     <= '0;
                        state_q    <= DIVIDE;
                    end else if (msCnt_q == TIMEOUT) begin
                        noSignal_q <= 1'b1;
                        bpm_q      <= '0;
                        state_q    <= IDLE;
                    end
                end
                DIVIDE: begin
                    // Sixteen shift/subtract cycles, then one cycle to publish the result.
                    if (step_q == LAST_STEP) begin
                        bpm_q      <= bpmSat;
                        bpmValid_q <= 1'b1;
                        noSignal_q <= 1'b0;
                        state_q    <= ARMED;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        step_q <= step_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign beat      = beat_q;
    assign bpm       = bpm_q;
    assign bpm_valid = bpmValid_q;
    assign no_signal = noSignal_q;

endmodule

// File: tb/tb_beat_rate_meter.sv
// Directed bench for beat_rate_meter with a 10-cycle ms tick; expected BPM values
// are queued when a qualifying rise is driven and matched when bpm_valid appears.
module tb_beat_rate_meter;

    localparam int TICK = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       over;
    logic       beat;
    logic [7:0] bpm;
    logic       bpm_valid;
    logic       no_signal;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beatCount = 0;
    int validCount = 0;
    int lastBeatCyc = 0;
    int expQ[$];

    beat_rate_meter #(.TICK_DIV(TICK)) dut (
        .clk(clk),
        .rst(rst),
        .over(over),
        .beat(beat),
        .bpm(bpm),
        .bpm_valid(bpm_valid),
        .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int at);
        while (cyc < at) nextCycle();
    endtask

    // Raise `over` during cycle `at`; hold of 0 leaves it high.
    task automatic applyStimulus(input int at, input int hold);
        waitUntil(at);
        over = 1'b1;
        if (hold > 0) begin
            repeat (hold) nextCycle();
            over = 1'b0;
        end
    endtask

    // Output monitor: counts beats and scores every bpm update against the queue.
    always @(negedge clk) begin
        if (beat === 1'b1) begin
            beatCount++;
            lastBeatCyc = cyc;
        end
        if (bpm_valid === 1'b1) begin
            int expBpm;
            validCount++;
            checkOutput("bpm_valid_expected", 32'(expQ.size() > 0), 32'd1);
            checkOutput("beat_valid_overlap", 32'(beat), 32'd0);
            expBpm = (expQ.size() > 0) ? expQ.pop_front() : -1;
            checkOutput("bpm_value", 32'(bpm), expBpm);
            checkOutput("bpm_latency", cyc - lastBeatCyc, 32'd17);
            checkOutput("no_signal_on_valid", 32'(no_signal), 32'd0);
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ref_cyc;
        int expBeats;
        int vcBefore;
        int ivMs[4]  = '{1000, 750, 857, 250};
        int ivBpm[4] = '{60, 80, 70, 240};

        rst  = 1'b1;
        over = 1'b0;
        repeat (3) nextCycle();
        checkOutput("reset_outputs", 32'({beat, bpm_valid, no_signal, bpm}), 32'h100);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            nextCycle();
            checkOutput("idle_quiet", 32'({beat, bpm_valid, no_signal, bpm}), 32'h100);
        end

        // First beat only arms the meter.
        ref_cyc  = cyc + 5;
        expBeats = 1;
        applyStimulus(ref_cyc, 2);
        repeat (20) nextCycle();
        checkOutput("first_beat_count", beatCount, expBeats);
        checkOutput("first_beat_no_valid", validCount, 32'd0);
        checkOutput("armed_no_signal", 32'(no_signal), 32'd1);
        checkOutput("armed_bpm", 32'(bpm), 32'd0);

        // Exact ms intervals: rise lands D*TICK cycles after the previous beat pulse.
        for (int k = 0; k < 4; k++) begin
            ref_cyc = ref_cyc + ivMs[k] * TICK + 1;
            expQ.push_back(ivBpm[k]);
            expBeats++;
            applyStimulus(ref_cyc, 2);
            repeat (20) nextCycle();
            checkOutput("interval_beat_count", beatCount, expBeats);
            checkOutput("interval_valid_count", validCount, k + 1);
            checkOutput("interval_bpm_hold", 32'(bpm), ivBpm[k]);
            checkOutput("interval_no_signal", 32'(no_signal), 32'd0);
        end

        // Refractory: a rise 100 ms after a beat is ignored and does not restart timing.
        applyStimulus(ref_cyc + 100 * TICK + 1, 2);
        repeat (20) nextCycle();
        checkOutput("refractory_reject", beatCount, expBeats);
        ref_cyc = ref_cyc + 800 * TICK + 1;
        expQ.push_back(75);
        expBeats++;
        applyStimulus(ref_cyc, 0);
        repeat (20) nextCycle();
        checkOutput("post_refractory_beat", beatCount, expBeats);
        checkOutput("post_refractory_bpm", 32'(bpm), 32'd75);

        // Over stays high: no further beats, timeout 3000 ms after the beat pulse.
        while (no_signal !== 1'b1 && cyc < ref_cyc + 30100) nextCycle();
        checkOutput("timeout_cycle", cyc, ref_cyc + 30002);
        checkOutput("timeout_no_signal", 32'(no_signal), 32'd1);
        checkOutput("timeout_bpm", 32'(bpm), 32'd0);
        waitUntil(ref_cyc + 31000);
        checkOutput("held_over_no_beats", beatCount, expBeats);
        over = 1'b0;

        // After timeout the first beat re-arms only; the second yields a rate.
        vcBefore = validCount;
        ref_cyc  = cyc + 5;
        expBeats++;
        applyStimulus(ref_cyc, 2);
        repeat (30) nextCycle();
        checkOutput("rearm_beat", beatCount, expBeats);
        checkOutput("rearm_no_valid", validCount, vcBefore);
        checkOutput("rearm_no_signal", 32'(no_signal), 32'd1);
        ref_cyc = ref_cyc + 600 * TICK + 1;
        expQ.push_back(100);
        expBeats++;
        applyStimulus(ref_cyc, 2);
        repeat (20) nextCycle();
        checkOutput("rearm_bpm", 32'(bpm), 32'd100);
        checkOutput("rearm_valid_count", validCount, vcBefore + 1);

        // Reset five cycles into DIVIDE aborts the division.
        vcBefore = validCount;
        ref_cyc  = ref_cyc + 300 * TICK + 1;
        expBeats++;
        applyStimulus(ref_cyc, 2);
        waitUntil(ref_cyc + 6);
        checkOutput("abort_beat_seen", beatCount, expBeats);
        rst = 1'b1;
        #1;
        checkOutput("abort_reset_outputs", 32'({beat, bpm_valid, no_signal, bpm}), 32'h100);
        repeat (3) nextCycle();
        rst = 1'b0;
        repeat (40) nextCycle();
        checkOutput("abort_no_valid", validCount, vcBefore);
        checkOutput("abort_outputs_after", 32'({beat, bpm_valid, no_signal, bpm}), 32'h100);
        checkOutput("queue_drained", expQ.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
